// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and per-stage stall/flush controls back to it
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] exe_rd_addr;
    logic              exe_mem_read;
    logic              exe_muldiv;
    logic              exe_mispredict;
    logic              imem_wait;
    logic              dmem_wait;
    logic              stall_if;
    logic              stall_id;
    logic              stall_exe;
    logic              stall_mem;
    logic              flush_id;
    logic              flush_exe;
    logic              flush_mem;
    logic              muldiv_done;
    logic [31:0]       stall_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, exe_rd_addr,
               exe_mem_read, exe_muldiv, exe_mispredict, imem_wait, dmem_wait,
        input  stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
               flush_mem, muldiv_done, stall_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, exe_rd_addr,
               exe_mem_read, exe_muldiv, exe_mispredict, imem_wait, dmem_wait,
        output stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
               flush_mem, muldiv_done, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush generation for memory wait, mispredict, MUL/DIV and load-use
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int REG_AW     = 5
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              mem_wait, load_use;
    logic              s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, done;

    assign rd       = bus.exe_rd_addr;
    assign rs1      = bus.id_rs1_addr;
    assign rs2      = bus.id_rs2_addr;
    assign mem_wait = bus.imem_wait | bus.dmem_wait;
    assign load_use = bus.exe_mem_read && rd != '0 &&
                      ((bus.id_rs1_used && rs1 == rd) || (bus.id_rs2_used && rs2 == rd));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        {s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, done} = '0;
        if (mem_wait) begin
            {s_if, s_id, s_exe, s_mem} = '1;
            if (state_q == BUSY) begin
                cnt_d   = cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q;
                state_d = cnt_q == 8'd0 ? HOLD : BUSY;
            end
        end else if (state_q == RUN) begin
            if (bus.exe_mispredict) begin
                {f_id, f_exe} = '1;
            end else if (bus.exe_muldiv) begin
                {s_if, s_id, s_exe, f_mem} = '1;
                state_d = BUSY;
                cnt_d   = 8'(MULDIV_LAT - 2);
            end else if (load_use) begin
                {s_if, s_id, f_exe} = '1;
            end
        end else if (state_q == BUSY && cnt_q != 8'd0) begin
            {s_if, s_id, s_exe, f_mem} = '1;
            cnt_d = cnt_q - 8'd1;
        end else begin
            done    = 1'b1;
            state_d = RUN;
        end
        // outputs are forced quiet for the whole reset cycle
        if (!rst) {s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, done} = '0;
        stall_cycles_d = (s_if && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_if     = s_if;
    assign bus.stall_id     = s_id;
    assign bus.stall_exe    = s_exe;
    assign bus.stall_mem    = s_mem;
    assign bus.flush_id     = f_id;
    assign bus.flush_exe    = f_exe;
    assign bus.flush_mem    = f_mem;
    assign bus.muldiv_done  = done;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle MUL/DIV, wait and reset sequences
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic       r;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       md;
        logic       mp;
        logic       iw;
        logic       dw;
        logic [7:0] ex;
    } vec_t;

    localparam logic [7:0] Z   = 8'b0000_0000;
    localparam logic [7:0] LU  = 8'b1100_0100;
    localparam logic [7:0] MP  = 8'b0000_1100;
    localparam logic [7:0] FRZ = 8'b1111_0000;
    localparam logic [7:0] MD  = 8'b1110_0010;
    localparam logic [7:0] DN  = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    vec_t        tbl [12];

    pipe_hazard_ctrl_if #(.REG_AW(5)) bus ();
    pipe_hazard_ctrl #(.MULDIV_LAT(4), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string n);
        rst                = v.r;
        bus.id_rs1_addr    = v.rs1;
        bus.id_rs2_addr    = v.rs2;
        bus.id_rs1_used    = v.u1;
        bus.id_rs2_used    = v.u2;
        bus.exe_rd_addr    = v.rd;
        bus.exe_mem_read   = v.mr;
        bus.exe_muldiv     = v.md;
        bus.exe_mispredict = v.mp;
        bus.imem_wait      = v.iw;
        bus.dmem_wait      = v.dw;
        #4;
        chk({n, " ctl"}, {24'd0, bus.stall_if, bus.stall_id, bus.stall_exe, bus.stall_mem,
            bus.flush_id, bus.flush_exe, bus.flush_mem, bus.muldiv_done}, {24'd0, v.ex});
        @(posedge clk);
        #1;
        exp_cnt = v.r ? exp_cnt + {31'd0, v.ex[7]} : 32'd0;
        chk({n, " stall_cycles"}, bus.stall_cycles, exp_cnt);
    endtask

    function automatic vec_t c(input logic r, input logic md, input logic mp,
                               input logic iw, input logic dw, input logic [7:0] ex);
        c = '{r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, md, mp, iw, dw, ex};
    endfunction

    initial begin
        tbl = '{
            '{1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z},
            '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU},
            '{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z},
            '{1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z},
            '{1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU},
            '{1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z},
            '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, MP},
            '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FRZ},
            '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FRZ},
            '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MP},
            '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MP},
            '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z}
        };
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 3; i++) run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MD), $sformatf("md_t%0d", i));
        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DN), "md_t3");
        run_vec(c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z), "md_after");

        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MD), "mdw_t0");
        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MD), "mdw_t1");
        for (int i = 2; i < 5; i++) run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FRZ), $sformatf("mdw_t%0d", i));
        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DN), "mdw_t5");
        run_vec(c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z), "mdw_after");

        for (int i = 0; i < 3; i++) run_vec(c(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, FRZ), $sformatf("mpw_t%0d", i));
        run_vec(c(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, MP), "mpw_t3");

        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MD), "rst_t0");
        run_vec(c(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z), "rst_t1");
        for (int i = 0; i < 3; i++) run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MD), $sformatf("rst_md_t%0d", i));
        run_vec(c(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DN), "rst_md_t3");
        run_vec(c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z), "rst_md_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
